// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker: data first, fetch forced after MAX_SKIP
// consecutive data grants taken while a fetch was waiting.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_SKIP = 4,
  parameter int SKIP_W   = 3
) (
  input  logic              i_req,
  input  logic              d_req,
  input  logic [SKIP_W-1:0] skip_cnt,
  output owner_t            grant,
  output logic [SKIP_W-1:0] skip_nxt
);

  localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_SKIP);

  function automatic logic [SKIP_W-1:0] sat_inc(input logic [SKIP_W-1:0] v);
    return (v >= SKIP_MAX) ? SKIP_MAX : v + 1'b1;
  endfunction

  logic starved;

  always_comb begin
    grant    = OWN_NONE;
    skip_nxt = skip_cnt;
    starved  = (skip_cnt == SKIP_MAX);
    if (d_req && !(i_req && starved)) begin
      grant = OWN_D;
      if (i_req) skip_nxt = sat_inc(skip_cnt);
    end else if (i_req) begin
      grant    = OWN_I;
      skip_nxt = '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// with one outstanding transaction and bounded fetch starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int MAX_SKIP = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_done,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_done,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SKIP_W = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);

  state_t              state_q;
  owner_t              owner_q;
  owner_t              grant_d;
  logic [SKIP_W-1:0]   skip_q;
  logic [SKIP_W-1:0]   skip_d;
  logic                we_q;
  logic                i_done_q;
  logic                d_done_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [STRB_W-1:0]   mem_wstrb_q;

  mem_arb_pick #(
    .MAX_SKIP (MAX_SKIP),
    .SKIP_W   (SKIP_W)
  ) u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .skip_cnt (skip_q),
    .grant    (grant_d),
    .skip_nxt (skip_d)
  );

  // The mem_* registers double as the grant latch; they are only non-zero in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      skip_q      <= '0;
      we_q        <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d != OWN_NONE) begin
            state_q   <= ISSUE;
            owner_q   <= grant_d;
            skip_q    <= skip_d;
            mem_req_q <= 1'b1;
            if (grant_d == OWN_D) begin
              we_q        <= d_we;
              mem_we_q    <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              mem_wstrb_q <= d_wstrb;
            end else begin
              we_q        <= 1'b0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= i_addr;
              mem_wdata_q <= '0;
              mem_wstrb_q <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            state_q     <= WAIT;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state_q <= DONE;
            if (owner_q == OWN_I) begin
              i_rdata_q <= mem_rdata;
              i_done_q  <= 1'b1;
            end else begin
              if (!we_q) d_rdata_q <= mem_rdata;
              d_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          owner_q <= OWN_NONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: transaction-level reference model
// on the memory side, done/rdata scoreboard checked by a separate monitor.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int MAXS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_done;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [SW-1:0] d_wstrb = '0;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_ready = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_SKIP(MAXS)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  typedef struct {
    int            own;   // 1 = fetch, 2 = data
    logic          we;
    logic [DW-1:0] data;
    int            cyc;   // cycle in which the done pulse must be visible
  } resp_t;
  resp_t sbq[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Stimulus knobs
  int i_rate = 0, d_rate = 0, i_keep = 0, d_keep = 0, we_mode = 0;
  int rdy_pct = 100, dly_min = 0, dly_max = 0, stale_pct = 0;
  bit stale_force = 0, do_reset = 0;

  // Reference model state
  int             phase = 0;        // 0 no transaction on the bus, 1 issuing, 2 awaiting response
  int             wcnt = 0;
  int             idle_from = 0;    // first cycle the arbiter may grant again
  int             d_streak = 0;     // data grants taken while a fetch waited
  int             own = 0;
  logic [104:0]   cap = '0;
  bit             i_pend = 0, d_pend = 0, i_seen = 0, d_seen = 0;
  logic           p_i = 0, p_d = 0, p_dwe = 0;
  logic [AW-1:0]  p_ia = '0, p_da = '0;
  logic [DW-1:0]  p_dwd = '0;
  logic [SW-1:0]  p_dws = '0;

  function automatic bit roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic new_d();
    d_addr  = $urandom;
    d_wdata = {$urandom, $urandom};
    d_wstrb = SW'($urandom);
    d_we    = (we_mode == 0) ? 1'($urandom_range(1)) : (we_mode == 1);
  endtask

  task automatic cycle();
    logic [104:0] act;
    bit           new_ok;
    int           win;
    resp_t        r;
    @(negedge clk);
    if (do_reset) begin
      reset = 1'b1;
      i_pend = 0; d_pend = 0; i_seen = 0; d_seen = 0;
      i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
      phase = 0; d_streak = 0; idle_from = cyc + 1;
      p_i = 1'b0; p_d = 1'b0;
      return;
    end
    reset = 1'b0;

    act    = {mem_we, mem_addr, mem_wdata, mem_wstrb};
    new_ok = (phase == 0) && (cyc - 1 >= idle_from) && (p_i || p_d);
    chk("mem_req", 128'(mem_req), 128'(new_ok || phase == 1));
    if (!mem_req) begin
      chk("mem_idle_zero", 128'(act), 128'(0));
    end else if (new_ok) begin
      if (p_i && p_d) win = (d_streak >= MAXS) ? 1 : 2;
      else            win = p_i ? 1 : 2;
      if (win == 1)  d_streak = 0;
      else if (p_i)  d_streak++;
      cap = (win == 1) ? {1'b0, p_ia, {DW{1'b0}}, {SW{1'b0}}} : {p_dwe, p_da, p_dwd, p_dws};
      chk("grant_attr", 128'(act), 128'(cap));
      phase = 1;
      own   = win;
    end else if (phase == 1) begin
      chk("issue_stable", 128'(act), 128'(cap));
    end

    mem_rdata = {$urandom, $urandom};
    if (phase == 2) begin
      if (wcnt == 0) begin
        mem_rvalid = 1'b1;
        r.own = own; r.we = cap[104]; r.data = mem_rdata; r.cyc = cyc + 1;
        sbq.push_back(r);
        phase     = 0;
        idle_from = cyc + 2;
      end else begin
        mem_rvalid = 1'b0;
        wcnt--;
      end
    end else begin
      mem_rvalid = stale_force || roll(stale_pct);
    end
    mem_ready = roll(rdy_pct);
    if (phase == 1 && mem_req && mem_ready) begin
      phase = 2;
      wcnt  = int'($urandom_range(dly_max, dly_min));
    end

    if (i_seen) begin
      i_seen = 0;
      if (roll(i_keep)) i_addr = $urandom;
      else              i_pend = 0;
    end else if (!i_pend && roll(i_rate)) begin
      i_pend = 1;
      i_addr = $urandom;
    end
    if (i_done) i_seen = 1;
    if (d_seen) begin
      d_seen = 0;
      if (roll(d_keep)) new_d();
      else              d_pend = 0;
    end else if (!d_pend && roll(d_rate)) begin
      d_pend = 1;
      new_d();
    end
    if (d_done) d_seen = 1;
    i_req = i_pend;
    d_req = d_pend;

    p_i = i_req; p_ia = i_addr;
    p_d = d_req; p_dwe = d_we; p_da = d_addr; p_dwd = d_wdata; p_dws = d_wstrb;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic knobs(input int ir, input int dr, input int ik, input int dk,
                       input int rp, input int dmin, input int dmax);
    i_rate = ir; d_rate = dr; i_keep = ik; d_keep = dk;
    rdy_pct = rp; dly_min = dmin; dly_max = dmax;
  endtask

  // Monitor: done pulses, their timing and the held rdata registers.
  initial begin
    logic [DW-1:0] exp_i;
    logic [DW-1:0] exp_d;
    logic [1:0]    exp_done;
    resp_t         r;
    exp_i = '0;
    exp_d = '0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        exp_i = '0;
        exp_d = '0;
        sbq.delete();
      end
      exp_done = 2'b00;
      if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        r = sbq.pop_front();
        if (r.cyc == cyc) begin
          exp_done = (r.own == 1) ? 2'b10 : 2'b01;
          if (!r.we) begin
            if (r.own == 1) exp_i = r.data;
            else            exp_d = r.data;
          end
        end
      end
      chk("done_pulse", 128'({i_done, d_done}), 128'(exp_done));
      chk("i_rdata", 128'(i_rdata), 128'(exp_i));
      chk("d_rdata", 128'(d_rdata), 128'(exp_d));
    end
  end

  initial begin
    do_reset = 1;
    run(3);
    do_reset = 0;
    cycle();
    chk("reset_ctl", 128'({i_done, d_done, mem_req, mem_we, mem_wstrb}), 128'(0));
    chk("reset_bus", 128'({mem_addr, mem_wdata}), 128'(0));
    chk("reset_rdata", {i_rdata, d_rdata}, 128'(0));

    knobs(30, 0, 0, 0, 100, 0, 0);   run(80);    // lone fetches, zero-latency memory
    we_mode = 1;
    knobs(100, 100, 0, 0, 100, 0, 0); run(80);   // simultaneous requests, stores
    we_mode = 0;
    knobs(100, 100, 0, 100, 100, 0, 0); run(120); // data re-requests back-to-back
    knobs(40, 40, 30, 30, 20, 0, 5); run(300);   // ready and response stalls

    knobs(60, 60, 0, 0, 100, 4, 6);
    for (int k = 0; k < 200 && phase != 2; k++) cycle();
    chk("reach_wait", 128'(phase), 128'(2));
    knobs(0, 0, 0, 0, 100, 0, 0);
    cycle();                         // lets the DUT enter WAIT
    do_reset = 1;
    cycle();
    do_reset = 0;
    stale_force = 1;
    cycle();
    chk("post_reset_ctl", 128'({i_done, d_done, mem_req, mem_we, mem_wstrb}), 128'(0));
    chk("post_reset_bus", 128'({mem_addr, mem_wdata}), 128'(0));
    chk("post_reset_rdata", {i_rdata, d_rdata}, 128'(0));
    run(2);
    stale_force = 0;

    stale_pct = 10;
    knobs(35, 35, 25, 25, 70, 0, 3); run(2500);
    stale_pct = 0;

    knobs(0, 0, 0, 0, 100, 0, 0);
    for (int k = 0; k < 500 && (phase != 0 || i_pend || d_pend || sbq.size() != 0); k++) cycle();
    run(4);
    chk("drain", 128'({phase != 0, i_pend, d_pend, sbq.size() != 0}), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch requester and the load/store (data) requester of the diablo core. It uses a req/done handshake on each requester side and a req/ready plus rvalid handshake on the memory side. At most one memory transaction is outstanding at any time. Data accesses have priority, and a bounded-starvation counter guarantees forward progress for instruction fetch.

Parameters:
ADDR_W, 32, byte address width on all ports
DATA_W, 64, data width on all ports
MAX_SKIP, 4, consecutive data grants allowed while i_req is pending before fetch is forced to win (>=1)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held high until i_done
i_addr  in  ADDR_W  fetch address
i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid
i_rdata  out  DATA_W  fetch read data, registered
d_req  in  1  data request; held high until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wstrb  in  DATA_W/8  store byte enables
d_done  out  1  one-cycle pulse: load/store complete, d_rdata valid for loads
d_rdata  out  DATA_W  load data, registered
mem_req  out  1  memory request valid
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  DATA_W/8  memory byte enables
mem_ready  in  1  memory accepts the request this cycle (when mem_req=1)
mem_rvalid  in  1  response/ack for the accepted request (loads and stores)
mem_rdata  in  DATA_W  memory read data, valid with mem_rvalid

Behaviour:
- Reset (synchronous, highest priority): state=IDLE, skip_cnt=0, owner=NONE. All outputs are 0: done pulses, rdata, and all mem_* outputs. Any in-flight memory response is dropped; the memory shares this reset.
- FSM states:
  - IDLE: arbitrate. If neither request is high, stay in IDLE.
  - ISSUE: mem_req=1 with the latched attributes. On mem_ready, go to WAIT.
  - WAIT: on mem_rvalid, capture mem_rdata into the owner's rdata register and go to DONE.
  - DONE: the owner's done pulse is 1 for exactly this cycle. No arbitration. Go to IDLE.
- Arbitration in IDLE:
  - If only one requester is high, it wins.
  - If both are high: data wins unless skip_cnt==MAX_SKIP, in which case fetch wins.
- Skip counter:
  - skip_cnt increments when data is granted while i_req=1.
  - It clears when fetch is granted.
  - It saturates at MAX_SKIP and is otherwise unchanged.
- Grant latching: on grant, the winner's addr/we/wdata/wstrb are latched (fetch uses we=0, wstrb=0). Requester input changes after grant are ignored until DONE.
- mem_* outputs come from the latched registers while in ISSUE; otherwise all mem_* outputs are 0.
- Minimum latency is 3 cycles from the first cycle req is high to done: req seen in IDLE at cycle 0, ISSUE with mem_ready=1 at cycle 1, WAIT with mem_rvalid=1 at cycle 2, DONE at cycle 3.
- Stall rules:
  - mem_ready=0 holds ISSUE indefinitely with stable mem_* outputs.
  - mem_rvalid=0 holds WAIT indefinitely.
  - mem_rvalid in any state other than WAIT is ignored.
- Requester contract: req drops or changes no earlier than the cycle after done. The DONE→IDLE gap guarantees a held req is never double-granted.
- rdata registers hold their value until the next completion for the same owner. For stores, d_rdata is unchanged.
- Back-to-back: a requester re-asserting req in the cycle after DONE is arbitrated normally in that IDLE cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - state_t enum {IDLE, ISSUE, WAIT, DONE}
  - owner_t enum {OWN_NONE, OWN_I, OWN_D}
- The priority/starvation picker is a natural small combinational sub-module, mem_arb_pick.
  - Inputs: i_req, d_req, skip_cnt.
  - Outputs: owner_t grant and skip_cnt next value.
- The FSM and latches stay in the top module.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, mem_ready=1 at once, mem_rvalid=1 with rdata=0xDEADBEEF_00000013 one cycle later -> mem_addr=0x100 and mem_we=0 in cycle 1, i_done=1 in cycle 3 with i_rdata=0xDEADBEEF_00000013, d_done never pulses.
- Collision: i_req and d_req both high in the same cycle, d_we=1, d_addr=0x2000, d_wstrb=0x0F -> store issued first with mem_we=1 and mem_wstrb=0x0F. After d_done, the fetch is issued; i_done follows exactly 4 cycles later with zero-latency memory.
- Starvation with MAX_SKIP=2: i_req held, d_req re-asserted immediately after each d_done -> grant order D, D, I, D, D, I; skip_cnt returns to 0 after each I grant.
- Memory stalls: mem_ready low for 5 cycles, then mem_rvalid delayed 3 cycles -> mem_* outputs stable throughout ISSUE, a single done pulse, and no spurious second mem_req.
- Reset in WAIT: assert reset for 1 cycle during WAIT, then deliver a stale mem_rvalid -> all outputs 0 after reset, no done pulse, and the next request completes normally.
- Held-request gap: requester keeps req high for one extra cycle after done -> it is granted again only once, for a new transaction starting in the IDLE cycle after DONE.
